// File: rtl/ram_rd_pkg.sv
// Shared types and default widths for the RAM burst reader.
package ram_rd_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM-side and output-stream signals of the RAM burst reader.
interface ram_burst_reader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, base_addr, length, ram_q, out_ready,
        output busy, done, ram_address, ram_wren, out_data, out_valid
    );

    modport slave (
        output start, base_addr, length, ram_q, out_ready,
        input  busy, done, ram_address, ram_wren, out_data, out_valid
    );

endinterface

// File: rtl/ram_rd_fifo.sv
// First-word fall-through FIFO; push and pop may coincide at any fill level.
module ram_rd_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic [CntW-1:0]   count
);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              pop_eff;

    assign pop_eff  = pop && (count_q != '0);
    assign count    = count_q;
    // Head is forced to zero when empty so nothing stale is ever visible.
    assign out_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since reads are gated by count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for ram1: issues consecutive reads under FIFO credit,
// tracks read latency with a valid shift line and streams words out in order.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clock,
    input logic                 reset_n,
    ram_burst_reader_if.master  bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SumW = $clog2(FIFO_DEPTH + RD_LAT) + 2;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT:0]   vld_shift;

    logic              issue;
    logic              push;
    logic              pop;
    logic              out_valid;
    logic              credit_ok;
    logic [CntW-1:0]   fifo_count;
    logic [SumW-1:0]   outstanding;

    // Reads in flight plus words buffered may never exceed the FIFO size,
    // so every returning word has a slot whatever the consumer does.
    assign outstanding = SumW'($countones(vld_q)) + SumW'(fifo_count);
    assign credit_ok   = outstanding < SumW'(FIFO_DEPTH);

    assign push      = vld_q[RD_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && bus.out_ready;

    assign bus.out_valid   = out_valid;
    assign bus.ram_wren    = 1'b0;
    assign bus.ram_address = issue ? next_addr_q : hold_addr_q;
    assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done        = (state_q == FINISH);

    // FSM next-state, issue decision and address/count bookkeeping.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    next_addr_d = bus.base_addr;
                    remaining_d = bus.length;
                    state_d     = (bus.length == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    next_addr_d = next_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the last word is handed over so done follows it directly.
                if ((vld_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latency line and held address next-state.
    always_comb begin
        vld_shift   = {vld_q, issue};
        vld_d       = vld_shift[RD_LAT-1:0];
        hold_addr_d = issue ? next_addr_q : hold_addr_q;
    end

    // State, counters and latency line registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            hold_addr_q <= '0;
            remaining_q <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            hold_addr_q <= hold_addr_d;
            remaining_q <= remaining_d;
            vld_q       <= vld_d;
        end
    end

    ram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.ram_q),
        .pop       (pop),
        .out_data  (bus.out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader with a two-stage ram1 model (mem[a] = A0000000 + a).
module tb_ram_burst_reader;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    ram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_burst_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ram1 model: address registered, then output registered (two clocks).
    logic [31:0] ram_stage;
    always @(posedge clock) begin
        ram_stage <= 32'hA000_0000 + {16'h0000, bus.ram_address};
        bus.ram_q <= ram_stage;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] addr_q[$];
    int          done_cnt, done_cyc, first_valid_cyc, addr_at_hold;
    bit          wren_seen, timeout, busy_at1, busy_at_done;

    function automatic logic ready_for(input int mode, input int hold, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc > hold);
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [31:0] word_at(input logic [15:0] base, input int i);
        logic [15:0] a;
        a = base + 16'(i);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    // Drives one burst and records what comes out; cycle 1 is the first after acceptance.
    task automatic run_burst(input logic [15:0] base, input logic [16:0] len,
                             input int mode, input int hold, input int restart_at);
        int cyc;
        bit fin;
        got_q.delete(); got_cyc.delete(); addr_q.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; addr_at_hold = -1;
        wren_seen = 0; timeout = 0; busy_at1 = 0; busy_at_done = 1;
        @(negedge clock);
        bus.start = 1'b1; bus.base_addr = base; bus.length = len;
        bus.out_ready = ready_for(mode, hold, 0);
        cyc = 0; fin = 0;
        while (!fin) begin
            @(negedge clock);
            cyc++;
            bus.start = (cyc == restart_at);
            if (cyc == restart_at) begin
                bus.base_addr = 16'h7777;
                bus.length    = 17'd3;
            end
            bus.out_ready = ready_for(mode, hold, cyc);
            if (cyc == 1) busy_at1 = bus.busy;
            if (bus.ram_wren) wren_seen = 1;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.busy && (addr_q.size() == 0 || addr_q[$] != bus.ram_address))
                addr_q.push_back(bus.ram_address);
            if (cyc == hold) addr_at_hold = addr_q.size();
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                got_cyc.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = bus.busy;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
            else if (cyc >= 1000) begin
                timeout = 1;
                fin     = 1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        checks++; if (bus.ram_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.ram_address); end
        checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", bus.ram_wren); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        run_burst(16'h0010, 17'd4, 0, 0, 0);
        checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got 1 want 0"); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_at(16'h0010, i)) begin
                errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_q[i], word_at(16'h0010, i));
            end
        end
        // Acceptance edge opens cycle 1; first word visible 1 + RD_LAT edges later.
        checks++; if (first_valid_cyc != 2 + RD_LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", first_valid_cyc, 2 + RD_LAT); end
        checks++; if (got_cyc.size() == 4 && got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL basic_throughput: got span %0d want 3", got_cyc[3] - got_cyc[0]); end
        checks++; if (got_cyc.size() == 0 || done_cyc != got_cyc[$] + 1) begin errors++; $display("FAIL basic_done_time: got %0d want last handshake + 1", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_at1); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [4];
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_burst(16'hFFFE, 17'd4, 0, 0, 0);
        checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL wrap_addr_count: got %0d want 4", addr_q.size()); end
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_q[i], exp_addr[i]); end
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_at(16'hFFFE, i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[i], word_at(16'hFFFE, i)); end
        end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", got_q.size()); end
    endtask

    task automatic test_backpressure();
        run_burst(16'h0100, 17'd16, 1, 20, 0);
        checks++; if (addr_at_hold != DEPTH) begin errors++; $display("FAIL bp_outstanding: got %0d want %0d", addr_at_hold, DEPTH); end
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_at(16'h0100, i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], word_at(16'h0100, i)); end
        end
        checks++; if (got_cyc.size() == 0 || got_cyc[0] != 21) begin errors++; $display("FAIL bp_first_handshake: got %0d want 21", got_cyc.size() ? got_cyc[0] : -1); end
        checks++; if (wren_seen) begin errors++; $display("FAIL bp_wren: got 1 want 0"); end
        checks++; if (done_cnt != 1 || timeout) begin errors++; $display("FAIL bp_done: got %0d pulses timeout %0d want 1/0", done_cnt, timeout); end
    endtask

    task automatic test_zero_length();
        run_burst(16'h0050, 17'd0, 0, 0, 0);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_time: got %0d want 1", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (first_valid_cyc != -1) begin errors++; $display("FAIL zero_valid: got cycle %0d want never", first_valid_cyc); end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", addr_q.size()); end
    endtask

    task automatic test_restart();
        run_burst(16'h0200, 17'd8, 0, 0, 3);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL restart_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_at(16'h0200, i)) begin errors++; $display("FAIL restart_data[%0d]: got %h want %h", i, got_q[i], word_at(16'h0200, i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        @(negedge clock);
        bus.start = 1'b1; bus.base_addr = 16'h0020; bus.length = 17'd10; bus.out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            @(negedge clock);
            cyc++;
            bus.start = 1'b0;
            if (bus.out_valid && bus.out_ready) n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL midrst_progress: got %0d want 3", n); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", bus.out_data); end
        checks++; if (bus.ram_address !== 16'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", bus.ram_address); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        @(negedge clock);
        reset_n = 1'b1;
        run_burst(16'h0000, 17'd2, 0, 0, 0);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== word_at(16'h0000, i)) begin errors++; $display("FAIL midrst_data[%0d]: got %h want %h", i, got_q[i], word_at(16'h0000, i)); end
        end
    endtask

    task automatic test_random();
        logic [15:0] base;
        int          len;
        for (int b = 0; b < 8; b++) begin
            base = ($urandom_range(0, 1) != 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                               : 16'($urandom_range(0, 16'hFFFF));
            len  = $urandom_range(1, 24);
            run_burst(base, 17'(len), 2, 0, 0);
            checks++; if (timeout) begin errors++; $display("FAIL rand%0d_timeout: got 1 want 0", b); end
            checks++; if (got_q.size() != len) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", b, got_q.size(), len); end
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== word_at(base, i)) begin errors++; $display("FAIL rand%0d_data[%0d]: got %h want %h", b, i, got_q[i], word_at(base, i)); end
            end
            checks++; if (addr_q.size() != len) begin errors++; $display("FAIL rand%0d_reads: got %0d want %0d", b, addr_q.size(), len); end
            for (int i = 0; i < addr_q.size(); i++) begin
                checks++;
                if (addr_q[i] !== 16'(base + 16'(i))) begin errors++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", b, i, addr_q[i], 16'(base + 16'(i))); end
            end
            checks++; if (got_cyc.size() == 0 || done_cyc != got_cyc[$] + 1 || done_cnt != 1) begin
                errors++; $display("FAIL rand%0d_done: got cycle %0d pulses %0d want last handshake + 1, 1 pulse", b, done_cyc, done_cnt);
            end
            checks++; if (wren_seen) begin errors++; $display("FAIL rand%0d_wren: got 1 want 0", b); end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
